nor_bus_responder: RTL and testbench
====================================

Name: nor_bus_responder

Overview:
- Synthesizable parallel-NOR target: the device end of the NOR bus driven by the team's NOR bus initiator.
- Samples CE#/WE#/OE# synchronously and serves reads from an internal word array after a programmable access latency.
- Programs words with NOR semantics, where bits can only go 1->0, and holds RY low for a programmable busy time.
- Used for FPGA loopback and initiator verification in place of the real flash.

Parameters:
- ADDRBITS, 26, width of the NOR address bus.
- DATABITS, 16, width of the NOR data bus.
- MEMBITS, 10, log2 of array depth; array address = nor_addr_i[MEMBITS-1:0].
- SYNC_STAGES, 2, synchronizer depth applied to control, address and data inputs alike.
- ACCESS_CYCLES, 8, cycles from read request detect to data drive.
- BUSY_CYCLES, 32, cycles RY is held low after a program.
- COUNTERBITS, 8, width of the shared wait counter.
- BUSY_WORD, 16'h0080, word driven on reads while busy.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset
- nor_addr_i  in  ADDRBITS  address from initiator
- nor_data_i  in  DATABITS  write data from initiator
- nor_ce_i  in  1  chip enable, active low
- nor_we_i  in  1  write enable, active low
- nor_oe_i  in  1  output enable, active low
- nor_data_o  out  DATABITS  read data
- nor_data_oe  out  1  1 = responder drives data bus
- nor_ry_o  out  1  1 = ready, 0 = busy
- prog_stb_o  out  1  one-cycle pulse per accepted program
- prog_addr_o  out  MEMBITS  array address of last program
- prog_data_o  out  DATABITS  word written to the array (old & new)

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous, active-high.
- Reset values:
  - nor_data_oe=0, nor_data_o=0, nor_ry_o=1, prog_stb_o=0, prog_addr_o=0, prog_data_o=0.
  - State IDLE, counter 0, synchronizer registers set to 1 for controls and 0 for address/data.
  - Array contents are not reset. At configuration the array initialises to all-ones (erased).
- Synchronization: ce/we/oe, addr and data each pass through SYNC_STAGES flops so they stay aligned. s_* denotes the synchronized copies. A we rising edge is s_we=1 with the previous s_we=0.
- States: IDLE, RD_WAIT, RD_DRIVE, BUSY. All outputs are registered.
- IDLE:
  - Write: s_ce=0 and s_we rising -> array[a] <= array[a] & s_data. Pulse prog_stb_o; load prog_addr_o/prog_data_o; nor_ry_o=0 from the next cycle; counter cleared; go to BUSY.
  - Read: s_ce=0, s_oe=0, s_we=1 -> latch s_addr, clear counter, go to RD_WAIT.
- RD_WAIT:
  - When counter==ACCESS_CYCLES-1, register array[latched addr] into nor_data_o, set nor_data_oe=1, go to RD_DRIVE.
  - s_ce=1 or s_oe=1 -> return to IDLE with no drive.
- RD_DRIVE:
  - Hold the drive while s_ce=0 and s_oe=0.
  - s_addr differs from the latched address -> nor_data_oe=0 next cycle, relatch, go to RD_WAIT (full latency again).
  - s_ce or s_oe high -> nor_data_oe=0 on the next cycle, go to IDLE.
- BUSY:
  - nor_ry_o=0. Release when counter==BUSY_CYCLES-1: nor_ry_o=1, go to IDLE.
  - Reads while busy: s_ce=0, s_oe=0 drives BUSY_WORD with no access latency (one cycle after detect). Drive drops one cycle after s_oe or s_ce rises.
  - Writes while busy are ignored, with no array change and no prog_stb_o.
- Conflicts:
  - s_we=0 and s_oe=0 together: the write edge has priority and the responder never drives while s_we=0.
  - A we rising edge with s_ce=1 is ignored.
- Latency:
  - Read data is valid on the bus SYNC_STAGES+ACCESS_CYCLES+1 cycles after CE#/OE# fall.
  - The program completes SYNC_STAGES+1 cycles after the WE# rise.
  - ACCESS_CYCLES must stay below the initiator's OE-low window; 8 fits the initiator defaults.
- Reset mid-operation: returns to IDLE immediately. Drive and busy drop and ry goes to 1. A program already committed to the array stays.
- Counter: COUNTERBITS wide, cleared on every state entry, saturates at its maximum.

Decomposition:
- Package nor_bus_pkg holds:
  - the state encodings IDLE/RD_WAIT/RD_DRIVE/BUSY;
  - the erased-word constant (all ones);
  - the shared NOR timing constants, also used by the initiator, so default wait counts stay matched.
- One sub-module, nor_sync_bus: a SYNC_STAGES-deep aligned synchronizer for ctrl+addr+data, with reset values as listed under Behaviour.
- The array is inferred inside the top as a single-port RAM with a read-modify-write on program.

Test Plan:
- Erased read: after reset, read addr 0x005 -> nor_data_oe=1 after 2+8+1 cycles, data 16'hFFFF, ry=1.
- Program 0x005 <- 16'hA5A5 -> prog_stb_o one cycle, prog_data_o=16'hA5A5, ry=0 for exactly 32 cycles; a later read returns 16'hA5A5.
- NOR AND rule: program 0x005 <- 16'h0FF0 over 16'hA5A5 -> read returns 16'h05A0; programming 16'hFFFF returns 16'h05A0 unchanged.
- Busy behaviour: read during BUSY -> 16'h0080 driven within 1 cycle of detect; a write during BUSY -> no prog_stb_o and the array is unchanged.
- Address change in RD_DRIVE: 0x001 -> 0x002 with OE held low -> nor_data_oe drops for the 8-cycle access, then drives the 0x002 contents.
- Reset mid-BUSY at cycle 10 -> next cycle ry=1, nor_data_oe=0; the programmed word persists on a later read.
- Loopback against the initiator at defaults: a wishbone write then read of 0x3FF with 16'h1234 -> the wishbone read returns 16'h1234.

Source files
------------

// File: rtl/nor_bus_pkg.sv
// Shared definitions for the parallel-NOR bus: responder state encoding,
// erased/busy words and the timing defaults the initiator is matched against.
package nor_bus_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    RD_DRIVE = 2'd2,
    BUSY     = 2'd3
  } nor_state_e;

  localparam int NOR_DATA_BITS     = 16;
  localparam int NOR_SYNC_STAGES   = 2;
  localparam int NOR_ACCESS_CYCLES = 8;
  localparam int NOR_BUSY_CYCLES   = 32;

  localparam logic [NOR_DATA_BITS-1:0] NOR_ERASED_WORD = '1;
  localparam logic [NOR_DATA_BITS-1:0] NOR_BUSY_WORD   = 16'h0080;

endpackage

// File: rtl/nor_sync_bus.sv
// Aligned multi-stage synchronizer for the NOR control strobes, address and
// data, so all three arrive at the responder on the same clock.
module nor_sync_bus #(
  parameter int ADDRBITS    = 26,
  parameter int DATABITS    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                nor_ce,
  input  logic                nor_we,
  input  logic                nor_oe,
  input  logic [ADDRBITS-1:0] nor_addr,
  input  logic [DATABITS-1:0] nor_data,
  output logic                s_ce,
  output logic                s_we,
  output logic                s_oe,
  output logic [ADDRBITS-1:0] s_addr,
  output logic [DATABITS-1:0] s_data
);

  localparam int W = 3 + ADDRBITS + DATABITS;
  // Strobes idle high (deasserted); address and data idle at zero.
  localparam logic [W-1:0] RST_VAL = {3'b111, {(ADDRBITS + DATABITS){1'b0}}};

  logic [W-1:0] pipe_q [SYNC_STAGES];

  // NOTE: state registers use non-blocking assignments so every stage samples
  // the value its predecessor held before this edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) pipe_q[i] <= RST_VAL;
    end else begin
      pipe_q[0] <= {nor_ce, nor_we, nor_oe, nor_addr, nor_data};
      for (int i = 1; i < SYNC_STAGES; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign {s_ce, s_we, s_oe, s_addr, s_data} = pipe_q[SYNC_STAGES-1];

endmodule

// File: rtl/nor_bus_responder.sv
// Device end of the parallel-NOR bus: latency-delayed reads from an internal
// word array, 1->0-only programming and a timed busy window on RY.
module nor_bus_responder
  import nor_bus_pkg::*;
#(
  parameter int ADDRBITS      = 26,
  parameter int DATABITS      = NOR_DATA_BITS,
  parameter int MEMBITS       = 10,
  parameter int SYNC_STAGES   = NOR_SYNC_STAGES,
  parameter int ACCESS_CYCLES = NOR_ACCESS_CYCLES,
  parameter int BUSY_CYCLES   = NOR_BUSY_CYCLES,
  parameter int COUNTERBITS   = 8,
  parameter logic [DATABITS-1:0] BUSY_WORD = NOR_BUSY_WORD
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [ADDRBITS-1:0] nor_addr_i,
  input  logic [DATABITS-1:0] nor_data_i,
  input  logic                nor_ce_i,
  input  logic                nor_we_i,
  input  logic                nor_oe_i,
  output logic [DATABITS-1:0] nor_data_o,
  output logic                nor_data_oe,
  output logic                nor_ry_o,
  output logic                prog_stb_o,
  output logic [MEMBITS-1:0]  prog_addr_o,
  output logic [DATABITS-1:0] prog_data_o
);

  localparam logic [DATABITS-1:0]    ERASED   = {DATABITS{NOR_ERASED_WORD[0]}};
  localparam logic [COUNTERBITS-1:0] ACC_LAST = COUNTERBITS'(ACCESS_CYCLES - 1);
  localparam logic [COUNTERBITS-1:0] BSY_LAST = COUNTERBITS'(BUSY_CYCLES - 1);

  logic                s_ce, s_we, s_oe;
  logic [ADDRBITS-1:0] s_addr;
  logic [DATABITS-1:0] s_data;

  nor_sync_bus #(
    .ADDRBITS    (ADDRBITS),
    .DATABITS    (DATABITS),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .nor_ce   (nor_ce_i),
    .nor_we   (nor_we_i),
    .nor_oe   (nor_oe_i),
    .nor_addr (nor_addr_i),
    .nor_data (nor_data_i),
    .s_ce     (s_ce),
    .s_we     (s_we),
    .s_oe     (s_oe),
    .s_addr   (s_addr),
    .s_data   (s_data)
  );

  nor_state_e          state_q, state_d;
  logic [COUNTERBITS-1:0] cnt_q, cnt_d;
  logic [ADDRBITS-1:0] addr_q, addr_d;
  logic [DATABITS-1:0] data_q, data_d;
  logic                oe_q, oe_d;
  logic                ry_q, ry_d;
  logic                stb_q, stb_d;
  logic [MEMBITS-1:0]  paddr_q, paddr_d;
  logic [DATABITS-1:0] pdata_q, pdata_d;
  logic                we_prev_q;

  // NOTE: the array is never reset and has no reset branch, so it maps onto
  // plain RAM. Words are stored inverted: power-up zeros read back as erased.
  logic [DATABITS-1:0] mem_inv [2**MEMBITS];

  logic [MEMBITS-1:0]  ram_idx;
  logic [DATABITS-1:0] rd_word, prog_word;
  logic                mem_we, we_rise, read_req;

  // Single port: IDLE addresses the array for program read-modify-write,
  // every other state reads the latched address.
  assign ram_idx   = (state_q == IDLE) ? s_addr[MEMBITS-1:0] : addr_q[MEMBITS-1:0];
  assign rd_word   = mem_inv[ram_idx] ^ ERASED;
  assign prog_word = rd_word & s_data;
  assign we_rise   = s_we & ~we_prev_q;
  assign read_req  = ~s_ce & ~s_oe & s_we;

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    oe_d    = 1'b0;
    ry_d    = 1'b1;
    stb_d   = 1'b0;
    paddr_d = paddr_q;
    pdata_d = pdata_q;
    mem_we  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (we_rise && !s_ce) begin
          mem_we  = 1'b1;
          stb_d   = 1'b1;
          paddr_d = ram_idx;
          pdata_d = prog_word;
          ry_d    = 1'b0;
          state_d = BUSY;
        end else if (read_req) begin
          addr_d  = s_addr;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (!read_req) begin
          state_d = IDLE;
        end else if (cnt_q == ACC_LAST) begin
          data_d  = rd_word;
          oe_d    = 1'b1;
          state_d = RD_DRIVE;
        end
      end
      RD_DRIVE: begin
        if (!read_req) begin
          state_d = IDLE;
        end else if (s_addr != addr_q) begin
          addr_d  = s_addr;
          state_d = RD_WAIT;
        end else begin
          oe_d = 1'b1;
        end
      end
      BUSY: begin
        ry_d = 1'b0;
        if (read_req) begin
          data_d = BUSY_WORD;
          oe_d   = 1'b1;
        end
        if (cnt_q == BSY_LAST) begin
          ry_d    = 1'b1;
          oe_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Counter restarts on every state entry and saturates otherwise.
    if (state_d != state_q) cnt_d = '0;
    else if (cnt_q == '1)   cnt_d = cnt_q;
    else                    cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      oe_q      <= 1'b0;
      ry_q      <= 1'b1;
      stb_q     <= 1'b0;
      paddr_q   <= '0;
      pdata_q   <= '0;
      we_prev_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      oe_q      <= oe_d;
      ry_q      <= ry_d;
      stb_q     <= stb_d;
      paddr_q   <= paddr_d;
      pdata_q   <= pdata_d;
      we_prev_q <= s_we;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we && !rst_i) mem_inv[ram_idx] <= prog_word ^ ERASED;
  end

  assign nor_data_o  = data_q;
  assign nor_data_oe = oe_q;
  assign nor_ry_o    = ry_q;
  assign prog_stb_o  = stb_q;
  assign prog_addr_o = paddr_q;
  assign prog_data_o = pdata_q;

endmodule

// File: tb/tb_nor_bus_responder.sv
// Directed plus randomized bench for nor_bus_responder, checked against a
// word-array model and the bus latencies derived from the stage counts.
module tb_nor_bus_responder;

  localparam int SYNC   = 2;
  localparam int ACC    = 8;
  localparam int BUSYC  = 32;
  localparam int RD_LAT = SYNC + ACC + 1;
  localparam int PG_LAT = SYNC + 1;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [25:0] nor_addr_i;
  logic [15:0] nor_data_i;
  logic        nor_ce_i, nor_we_i, nor_oe_i;
  logic [15:0] nor_data_o;
  logic        nor_data_oe, nor_ry_o, prog_stb_o;
  logic [9:0]  prog_addr_o;
  logic [15:0] prog_data_o;

  nor_bus_responder dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .nor_addr_i  (nor_addr_i),
    .nor_data_i  (nor_data_i),
    .nor_ce_i    (nor_ce_i),
    .nor_we_i    (nor_we_i),
    .nor_oe_i    (nor_oe_i),
    .nor_data_o  (nor_data_o),
    .nor_data_oe (nor_data_oe),
    .nor_ry_o    (nor_ry_o),
    .prog_stb_o  (prog_stb_o),
    .prog_addr_o (prog_addr_o),
    .prog_data_o (prog_data_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [15:0] model_mem [1024];

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    nor_ce_i = 1'b1;
    nor_we_i = 1'b1;
    nor_oe_i = 1'b1;
  endtask

  // Full read: latency, data and release of the drive after OE# rises.
  task automatic nor_read(input logic [25:0] a, input string tag);
    int t0;
    nor_addr_i = a;
    nor_ce_i = 1'b0; nor_oe_i = 1'b0; nor_we_i = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (nor_data_oe) break;
    end
    check({tag, "_lat"}, cyc - t0, RD_LAT);
    check({tag, "_data"}, nor_data_o, model_mem[a[9:0]]);
    check({tag, "_ry"}, nor_ry_o, 1'b1);
    bus_idle();
    repeat (SYNC + 1) tick();
    check({tag, "_release"}, nor_data_oe, 1'b0);
  endtask

  // Program up to the strobe; returns the cycle at which RY went low.
  task automatic nor_program(input logic [25:0] a, input logic [15:0] d,
                             input string tag, output int t_fall);
    int t0;
    logic [15:0] exp;
    nor_addr_i = a; nor_data_i = d;
    nor_ce_i = 1'b0; nor_oe_i = 1'b1; nor_we_i = 1'b0;
    repeat (3) tick();
    nor_we_i = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (prog_stb_o) break;
    end
    exp = model_mem[a[9:0]] & d;
    check({tag, "_plat"}, cyc - t0, PG_LAT);
    check({tag, "_paddr"}, prog_addr_o, a[9:0]);
    check({tag, "_pdata"}, prog_data_o, exp);
    check({tag, "_ry_low"}, nor_ry_o, 1'b0);
    model_mem[a[9:0]] = exp;
    t_fall = cyc;
    bus_idle();
    tick();
    check({tag, "_stb_pulse"}, prog_stb_o, 1'b0);
  endtask

  task automatic wait_ready(input int t_fall, input string tag);
    for (int i = 0; i < 100; i++) begin
      if (nor_ry_o) break;
      tick();
    end
    check({tag, "_busy_len"}, cyc - t_fall, BUSYC);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int tf, t0, drives, stbs;
    logic [25:0] a;
    logic [15:0] d;

    for (int i = 0; i < 1024; i++) model_mem[i] = 16'hFFFF;
    rst_i = 1'b1; bus_idle(); nor_addr_i = '0; nor_data_i = '0;
    repeat (3) tick();
    rst_i = 1'b0;
    tick();
    check("rst_oe", nor_data_oe, 1'b0);
    check("rst_data", nor_data_o, 16'h0000);
    check("rst_ry", nor_ry_o, 1'b1);
    check("rst_stb", prog_stb_o, 1'b0);
    check("rst_paddr", prog_addr_o, 10'h000);
    check("rst_pdata", prog_data_o, 16'h0000);

    // Erased read, program, AND rule.
    nor_read(26'h005, "erased");
    check("erased_const", nor_data_o, 16'hFFFF);
    nor_program(26'h005, 16'hA5A5, "pgA5", tf);
    wait_ready(tf, "pgA5");
    nor_read(26'h005, "rdA5");
    nor_program(26'h005, 16'h0FF0, "pg0FF0", tf);
    wait_ready(tf, "pg0FF0");
    nor_read(26'h005, "rd05A0");
    check("and_rule", nor_data_o, 16'h05A0);
    nor_program(26'h005, 16'hFFFF, "pgFFFF", tf);
    wait_ready(tf, "pgFFFF");
    nor_read(26'h005, "rd05A0b");

    // Reads and writes while busy.
    nor_program(26'h006, 16'h3C3C, "pgbusy", tf);
    nor_ce_i = 1'b0; nor_oe_i = 1'b0; nor_we_i = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (nor_data_oe) break;
    end
    check("busy_rd_lat", cyc - t0, SYNC + 1);
    check("busy_rd_word", nor_data_o, 16'h0080);
    bus_idle();
    repeat (SYNC + 1) tick();
    check("busy_rd_release", nor_data_oe, 1'b0);
    nor_addr_i = 26'h006; nor_data_i = 16'h0000;
    nor_ce_i = 1'b0; nor_we_i = 1'b0;
    repeat (3) tick();
    nor_we_i = 1'b1;
    stbs = 0;
    repeat (6) begin tick(); if (prog_stb_o) stbs++; end
    check("busy_wr_ignored", stbs, 0);
    bus_idle();
    wait_ready(tf, "pgbusy");
    nor_read(26'h006, "busy_wr_unchanged");

    // WE# edge with CE# high is not a program.
    nor_ce_i = 1'b1; nor_we_i = 1'b0; nor_addr_i = 26'h006; nor_data_i = 16'h0000;
    repeat (3) tick();
    nor_we_i = 1'b1;
    stbs = 0;
    repeat (6) begin tick(); if (prog_stb_o) stbs++; end
    check("ce_high_wr_stb", stbs, 0);
    check("ce_high_wr_ry", nor_ry_o, 1'b1);

    // WE# and OE# low together: no drive, then the write edge wins.
    nor_addr_i = 26'h020; nor_data_i = 16'h5A0F;
    nor_ce_i = 1'b0; nor_oe_i = 1'b0; nor_we_i = 1'b0;
    drives = 0;
    repeat (14) begin tick(); if (nor_data_oe) drives++; end
    check("conflict_no_drive", drives, 0);
    nor_we_i = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (prog_stb_o) break;
    end
    check("conflict_plat", cyc - t0, PG_LAT);
    check("conflict_pdata", prog_data_o, 16'h5A0F);
    model_mem[10'h020] = model_mem[10'h020] & 16'h5A0F;
    tf = cyc;
    bus_idle();
    wait_ready(tf, "conflict");
    nor_read(26'h020, "conflict_rd");

    // Address change while driving restarts the full access.
    nor_program(26'h001, 16'h1111, "pg1", tf);
    wait_ready(tf, "pg1");
    nor_program(26'h002, 16'h2222, "pg2", tf);
    wait_ready(tf, "pg2");
    nor_addr_i = 26'h001; nor_ce_i = 1'b0; nor_oe_i = 1'b0; nor_we_i = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 40; i++) begin tick(); if (nor_data_oe) break; end
    check("achg_lat1", cyc - t0, RD_LAT);
    check("achg_data1", nor_data_o, model_mem[1]);
    nor_addr_i = 26'h002;
    t0 = cyc;
    repeat (SYNC + 1) tick();
    check("achg_drop", nor_data_oe, 1'b0);
    for (int i = 0; i < 40; i++) begin tick(); if (nor_data_oe) break; end
    check("achg_lat2", cyc - t0, RD_LAT);
    check("achg_data2", nor_data_o, model_mem[2]);
    bus_idle();
    repeat (SYNC + 1) tick();

    // Reset ten cycles into the busy window.
    nor_program(26'h040, 16'h7E81, "pgrst", tf);
    while (cyc - tf < 10) tick();
    rst_i = 1'b1;
    tick();
    check("midrst_ry", nor_ry_o, 1'b1);
    check("midrst_oe", nor_data_oe, 1'b0);
    rst_i = 1'b0;
    tick();
    nor_read(26'h040, "midrst_persist");

    // Loopback-style write then read at the top of the array.
    nor_program(26'h3FF, 16'h1234, "loop", tf);
    wait_ready(tf, "loop");
    nor_read(26'h3FF, "loop_rd");
    check("loop_value", nor_data_o, 16'h1234);

    // Random programs/reads over a small window; upper address bits alias.
    for (int n = 0; n < 16; n++) begin
      a = 26'($urandom());
      a[9:0] = 10'(16 + $urandom_range(0, 7));
      d = 16'($urandom());
      if ($urandom_range(0, 2) == 0) begin
        nor_program(a, d, "rnd_pg", tf);
        wait_ready(tf, "rnd_pg");
      end else begin
        nor_read(a, "rnd_rd");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
